// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM encoding and constants for seq_stream_sched
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_REPORT
  } state_t;

  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_CNT_W     = 5;

  // Saturation ceiling of a w-bit match counter.
  function automatic int cnt_sat(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/seq_rr_arb.sv
// rtl/seq_rr_arb.sv - combinational round-robin pick starting at i_ptr
module seq_rr_arb
  import seq_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [ID_W-1:0]  o_id,
  output logic             o_valid
);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    o_id     = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ID_W'((int'(i_ptr) + i) % N_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid         = 1'b1;
        o_onehot[w_idx] = 1'b1;
        o_id            = w_idx;
      end
    end
  end

endmodule

// File: rtl/seq_stream_sched.sv
// rtl/seq_stream_sched.sv - round-robin frame scheduler sharing one 10110 detector
// Defining SEQ_SCHED_ABORT_EN adds o_aborted and ends a frame when the winner drops req.
module seq_stream_sched
  import seq_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ID_W      = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_bit_in,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_bit_rdy,
  output logic             o_det_clr,
  output logic             o_det_in,
  input  logic             i_det_out,
`ifdef SEQ_SCHED_ABORT_EN
  output logic             o_aborted,
`endif
  output logic             o_done,
  output logic [ID_W-1:0]  o_done_id,
  output logic [CNT_W-1:0] o_match_cnt
);

  localparam int BC_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  state_t           r_state, w_state_next;
  logic [ID_W-1:0]  r_ptr, r_winner, r_done_id;
  logic [N_REQ-1:0] r_grant_oh;
  logic [BC_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0] r_cnt, r_match, w_cnt_next;
  logic [N_REQ-1:0] w_arb_oh;
  logic [ID_W-1:0]  w_arb_id;
  logic             w_arb_valid, w_last, w_sample, w_abort;

  seq_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_oh),
    .o_id     (w_arb_id),
    .o_valid  (w_arb_valid)
  );

  assign w_last = (r_bit_cnt == BC_W'(FRAME_LEN - 1));
  // det_out lags det_in by one cycle, so the first STREAM cycle carries nothing new.
  assign w_sample = ((r_state == ST_STREAM) && (r_bit_cnt != '0)) || (r_state == ST_DRAIN);
`ifdef SEQ_SCHED_ABORT_EN
  assign w_abort = (r_state == ST_STREAM) && !i_req[r_winner];
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_winner   <= '0;
      r_grant_oh <= '0;
      r_bit_cnt  <= '0;
      r_cnt      <= '0;
      r_done_id  <= '0;
      r_match    <= '0;
`ifdef SEQ_SCHED_ABORT_EN
      o_aborted  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_cnt <= (r_state == ST_STREAM) ? r_bit_cnt + BC_W'(1) : '0;
      if (r_state == ST_IDLE && w_arb_valid) begin
        r_winner   <= w_arb_id;
        r_grant_oh <= w_arb_oh;
      end
      if (w_state_next == ST_REPORT) begin
        r_done_id <= r_winner;
        r_match   <= w_cnt_next;
`ifdef SEQ_SCHED_ABORT_EN
        o_aborted <= w_abort;
`endif
      end
      if (r_state == ST_REPORT)
        r_ptr <= (r_winner == ID_W'(N_REQ - 1)) ? '0 : r_winner + ID_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE:   if (w_arb_valid) w_state_next = ST_CLEAR;
      ST_CLEAR:  w_state_next = ST_STREAM;
      ST_STREAM: if (w_abort) w_state_next = ST_REPORT;
                 else if (w_last) w_state_next = ST_DRAIN;
      ST_DRAIN:  w_state_next = ST_REPORT;
      ST_REPORT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (w_state_next == ST_CLEAR)
      w_cnt_next = '0;
    else if (w_sample && i_det_out && r_cnt != CNT_MAX)
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_comb begin
    o_grant   = '0;
    o_bit_rdy = 1'b0;
    o_det_clr = 1'b0;
    o_det_in  = 1'b0;
    o_done    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        o_grant   = r_grant_oh;
        o_det_clr = 1'b1;
      end
      ST_STREAM: begin
        o_grant   = r_grant_oh;
        o_bit_rdy = 1'b1;
        o_det_in  = i_bit_in[r_winner];
      end
      ST_DRAIN:  o_grant = r_grant_oh;
      ST_REPORT: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_done_id   = r_done_id;
  assign o_match_cnt = r_match;

endmodule

// File: tb/tb_seq_stream_sched.sv
// tb/tb_seq_stream_sched.sv - scoreboard bench for seq_stream_sched with a 10110 detector model
module tb_seq_stream_sched;

  localparam int N_REQ = 4, FRAME_LEN = 16, CNT_W = 2, ID_W = 2;
  localparam int CNT_MAX = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req = '0, bit_in = '0, grant;
  logic             bit_rdy, det_clr, det_in, det_out, done;
  logic [ID_W-1:0]  done_id;
  logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_SCHED_ABORT_EN
  logic             aborted;
`endif

  seq_stream_sched #(.N_REQ(N_REQ), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_bit_in    (bit_in),
    .o_grant     (grant),
    .o_bit_rdy   (bit_rdy),
    .o_det_clr   (det_clr),
    .o_det_in    (det_in),
    .i_det_out   (det_out),
`ifdef SEQ_SCHED_ABORT_EN
    .o_aborted   (aborted),
`endif
    .o_done      (done),
    .o_done_id   (done_id),
    .o_match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  // Moore 10110 detector with overlap; state 5 means the pattern just completed.
  logic [2:0] d_st = 3'd0;
  assign det_out = (d_st == 3'd5);
  always @(posedge clk) begin
    if (det_clr) d_st <= 3'd0;
    else case (d_st)
      3'd0: d_st <= det_in ? 3'd1 : 3'd0;
      3'd1: d_st <= det_in ? 3'd1 : 3'd2;
      3'd2: d_st <= det_in ? 3'd3 : 3'd0;
      3'd3: d_st <= det_in ? 3'd4 : 3'd2;
      3'd4: d_st <= det_in ? 3'd1 : 3'd5;
      default: d_st <= det_in ? 3'd3 : 3'd0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int cnt; int ab;} exp_t;
  exp_t        sb[$];
  logic [15:0] pat [N_REQ];
  int          frames_left [N_REQ];
  int          checks = 0, errors = 0;
  int          pos = 0, abort_id = -1, abort_at = -1;
  int          first_done_cyc = -1, spacing = -1, last_done = -1;

  function automatic int exp_hits(input logic [15:0] p);
    logic [4:0] w;
    int n;
    w = '0;
    n = 0;
    for (int i = 15; i >= 0; i--) begin
      w = {w[3:0], p[i]};
      if (i <= 11 && w == 5'b10110) n++;
    end
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic push_exp(input int id, input int cnt, input int ab);
    exp_t e;
    e.id = id; e.cnt = cnt; e.ab = ab;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    pos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    first_done_cyc = -1; spacing = -1; last_done = -1;
    abort_id = -1; abort_at = -1;
  endtask

  task automatic service(input int budget, input string name);
    exp_t e;
    int   n, g;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (det_clr) begin
        checks++;
        if (grant !== (4'b0001 << sb[0].id)) begin
          errors++;
          $display("FAIL %s grant: got %b, expected id %0d", name, grant, sb[0].id);
        end
        pos = 0;
      end
      if (done) begin
        e = sb.pop_front();
        checks++;
        if (done_id !== 2'(e.id)) begin
          errors++;
          $display("FAIL %s done_id: got %0d, expected %0d", name, done_id, e.id);
        end
        checks++;
        if (match_cnt !== 2'(e.cnt)) begin
          errors++;
          $display("FAIL %s match_cnt: got %0d, expected %0d", name, match_cnt, e.cnt);
        end
`ifdef SEQ_SCHED_ABORT_EN
        checks++;
        if (aborted !== 1'(e.ab)) begin
          errors++;
          $display("FAIL %s aborted: got %b, expected %0d", name, aborted, e.ab);
        end
`endif
        if (first_done_cyc >= 0) begin
          checks++;
          if (cyc !== first_done_cyc) begin
            errors++;
            $display("FAIL %s done latency: at cycle %0d, expected %0d", name, cyc, first_done_cyc);
          end
          first_done_cyc = -1;
        end
        if (spacing > 0 && last_done >= 0) begin
          checks++;
          if (cyc - last_done !== spacing) begin
            errors++;
            $display("FAIL %s done spacing: got %0d, expected %0d", name, cyc - last_done, spacing);
          end
        end
        last_done = cyc;
        frames_left[e.id]--;
        if (frames_left[e.id] <= 0) req[e.id] = 1'b0;
      end
      if (bit_rdy && sb.size() > 0) begin
        g = sb[0].id;
        bit_in = 4'($urandom);
        bit_in[g] = pat[g][15 - pos];
        if (g == abort_id && pos == abort_at) req[g] = 1'b0;
        pos++;
      end else begin
        checks++;
        if (det_in !== 1'b0) begin
          errors++;
          $display("FAIL %s det_in outside stream: got %b, expected 0", name, det_in);
        end
        bit_in = 4'($urandom);
      end
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d frames outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({grant, bit_rdy, det_clr, det_in, done, done_id, match_cnt} !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle outputs: got %h, expected 000",
                 {grant, bit_rdy, det_clr, det_in, done, done_id, match_cnt});
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    pat[0] = 16'b1011010110000000;
    frames_left[0] = 1;
    push_exp(0, 2, 0);
    req[0] = 1'b1;
    first_done_cyc = cyc + 19;
    service(60, "single");
  endtask

  task automatic test_round_robin();
    do_reset();
    pat[0] = 16'b1011010110000000;
    pat[1] = 16'b0000000000010110;
    pat[2] = 16'hFFFF;
    pat[3] = 16'b1011011011011011;
    frames_left[0] = 2; frames_left[1] = 1; frames_left[2] = 1; frames_left[3] = 1;
    push_exp(0, exp_hits(pat[0]), 0);
    push_exp(1, exp_hits(pat[1]), 0);
    push_exp(2, exp_hits(pat[2]), 0);
    push_exp(3, exp_hits(pat[3]), 0);
    push_exp(0, exp_hits(pat[0]), 0);
    spacing = 20;
    req = 4'b1111;
    service(200, "round_robin");
  endtask

  task automatic test_clear_isolation();
    do_reset();
    pat[2] = 16'h0000;
    frames_left[2] = 1;
    push_exp(2, 0, 0);
    req[2] = 1'b1;
    service(60, "iso_zero");
    @(negedge clk);
    pat[2] = 16'b1011010110101101;
    frames_left[2] = 1;
    push_exp(2, exp_hits(pat[2]), 0);
    req[2] = 1'b1;
    service(60, "iso_match");
  endtask

  task automatic test_saturation();
    do_reset();
    pat[3] = 16'b1011011011011011;
    frames_left[3] = 1;
    push_exp(3, 3, 0);
    req[3] = 1'b1;
    service(60, "saturate");
  endtask

  task automatic test_reset_mid_frame();
    int n;
    bit hit;
    do_reset();
    pat[2] = 16'b1011011011011011;
    req[2] = 1'b1;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      if (det_clr) pos = 0;
      if (bit_rdy) begin
        if (pos == 7) hit = 1'b1;
        else begin
          bit_in[2] = pat[2][15 - pos];
          pos++;
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midreset reach_bit7: got %0d bits, expected 7", pos);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, bit_rdy, det_clr, det_in, done} !== 8'h00) begin
      errors++;
      $display("FAIL midreset outputs: got %h, expected 00", {grant, bit_rdy, det_clr, det_in, done});
    end
    req = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL midreset held: done=%b grant=%b, expected 0/0000", done, grant);
      end
    end
    rst_n = 1'b1;
    pat[2] = 16'b1011010110101101;
    frames_left[2] = 1;
    push_exp(2, exp_hits(pat[2]), 0);
    req[2] = 1'b1;
    service(60, "midreset_clean");
  endtask

  task automatic test_req_drop();
    do_reset();
    pat[1] = 16'b1011000000000000;
    frames_left[1] = 1;
    abort_id = 1;
    abort_at = 5;
`ifdef SEQ_SCHED_ABORT_EN
    push_exp(1, 1, 1);
`else
    push_exp(1, exp_hits(pat[1]), 0);
`endif
    req[1] = 1'b1;
    service(60, "req_drop");
    abort_id = -1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clear_isolation();
    test_saturation();
    test_reset_mid_frame();
    test_req_drop();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
